seq_gen: RTL and testbench

Serial pattern transmitter. It loads a PAT_W-bit pattern and shifts it out MSB-first on a one-bit serial line, repeated a programmed number of times with an optional idle gap between repetitions. It sits at the driving end of the serial bit stream that the team's Mealy sequence detectors consume. It serves as the stimulus source for detector loopback and as an on-chip pattern injector.

---
 rtl/seq_pkg.sv | 19 +
 rtl/seq_gen_if.sv | 35 +++
 rtl/seq_gen_piso_shift.sv | 33 +++
 rtl/seq_gen.sv | 150 +++++++++++++++
 tb/tb_seq_gen.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/seq_pkg.sv
// seq_pkg: shared types and constants for the serial pattern transmitter.
//   state_t   - FSM state encoding (IDLE/SHIFT/GAP/DONE)
//   DEF_PAT_4 - default 4-bit pattern (1010)
//   REPS_W    - width of the repetition count
//   GAP_W     - width of the inter-repetition gap count
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] DEF_PAT_4 = 4'b1010;
  localparam int         REPS_W    = 8;
  localparam int         GAP_W     = 4;

endpackage

// File: rtl/seq_gen_if.sv
// seq_gen_if: control/data bundle of the serial pattern transmitter.
//   Requester side (master) drives: start, use_def, pattern, reps, gap, abort.
//   Transmitter side (slave) drives: x_out, valid, busy, done, dbg_state.
// Handshake: a burst request is a level on start that the transmitter samples
// only while idle; the data fields are captured on that same edge. valid marks
// every cycle in which x_out carries a pattern bit; there is no back-pressure.
// dbg_state mirrors the FSM state register for observation.
interface seq_gen_if #(
  parameter int PAT_W = 4
);
  import seq_pkg::*;

  logic              start;
  logic              use_def;
  logic [PAT_W-1:0]  pattern;
  logic [REPS_W-1:0] reps;
  logic [GAP_W-1:0]  gap;
  logic              abort;
  logic              x_out;
  logic              valid;
  logic              busy;
  logic              done;
  state_t            dbg_state;

  modport master (
    output start, use_def, pattern, reps, gap, abort,
    input  x_out, valid, busy, done, dbg_state
  );

  modport slave (
    input  start, use_def, pattern, reps, gap, abort,
    output x_out, valid, busy, done, dbg_state
  );

endinterface

// File: rtl/seq_gen_piso_shift.sv
// piso_shift: PAT_W-wide parallel-load, serial-out shift register, MSB first.
//   clk     - rising-edge clock
//   reset   - asynchronous active-low reset (clears the register)
//   i_load  - load i_data (has priority over i_shift)
//   i_shift - shift left by one, filling with 0
//   i_data  - parallel load value
//   o_msb   - current MSB
module piso_shift #(
  parameter int PAT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [PAT_W-1:0] i_data,
  output logic             o_msb
);

  logic [PAT_W-1:0] r_sreg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sreg <= '0;
    end else if (i_load) begin
      r_sreg <= i_data;
    end else if (i_shift) begin
      r_sreg <= {r_sreg[PAT_W-2:0], 1'b0};
    end
  end

  assign o_msb = r_sreg[PAT_W-1];

endmodule

// File: rtl/seq_gen.sv
// seq_gen: serial pattern transmitter. Sends a PAT_W-bit pattern MSB-first,
// repeated reps times with gap idle cycles between repetitions.
//   clk   - rising-edge clock
//   reset - asynchronous active-low reset
//   bus   - seq_gen_if.slave (start/use_def/pattern/reps/gap/abort in,
//           x_out/valid/busy/done/dbg_state out)
// All outputs are decoded from registered state and registered data only.
module seq_gen
  import seq_pkg::*;
#(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(DEF_PAT_4)
) (
  input  logic      clk,
  input  logic      reset,
  seq_gen_if.slave  bus
);

  localparam int               CNT_W    = $clog2(PAT_W);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(PAT_W - 1);

  state_t            r_state,   w_state_nxt;
  logic [PAT_W-1:0]  r_pat,     w_pat_nxt;
  logic [CNT_W-1:0]  r_bit_cnt, w_bit_nxt;
  logic [REPS_W-1:0] r_rep_cnt, w_rep_nxt;
  logic [GAP_W-1:0]  r_gap_ld,  w_gap_ld_nxt;
  logic [GAP_W-1:0]  r_gap_cnt, w_gap_nxt;
  logic              w_load;
  logic              w_shift;
  logic [PAT_W-1:0]  w_load_val;
  logic [PAT_W-1:0]  w_sel_pat;
  logic              w_msb;

  assign w_sel_pat = bus.use_def ? DEF_PAT : bus.pattern;

  piso_shift #(.PAT_W(PAT_W)) u_shift (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_data  (w_load_val),
    .o_msb   (w_msb)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_pat     <= '0;
      r_bit_cnt <= '0;
      r_rep_cnt <= '0;
      r_gap_ld  <= '0;
      r_gap_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pat     <= w_pat_nxt;
      r_bit_cnt <= w_bit_nxt;
      r_rep_cnt <= w_rep_nxt;
      r_gap_ld  <= w_gap_ld_nxt;
      r_gap_cnt <= w_gap_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_pat_nxt    = r_pat;
    w_bit_nxt    = r_bit_cnt;
    w_rep_nxt    = r_rep_cnt;
    w_gap_ld_nxt = r_gap_ld;
    w_gap_nxt    = r_gap_cnt;
    w_load       = 1'b0;
    w_shift      = 1'b0;
    w_load_val   = r_pat;

    case (r_state)
      IDLE: begin
        // start beats abort here; abort has nothing to cancel in IDLE.
        if (bus.start) begin
          if (bus.reps != '0) begin
            w_pat_nxt    = w_sel_pat;
            w_load       = 1'b1;
            w_load_val   = w_sel_pat;
            w_rep_nxt    = bus.reps;
            w_gap_ld_nxt = bus.gap;
            w_bit_nxt    = BIT_LAST;
            w_state_nxt  = SHIFT;
          end else begin
            w_state_nxt = DONE;
          end
        end
      end

      SHIFT, GAP: begin
        if (bus.abort) begin
          // Abort drops everything back to the reset picture, no done pulse.
          w_state_nxt  = IDLE;
          w_pat_nxt    = '0;
          w_bit_nxt    = '0;
          w_rep_nxt    = '0;
          w_gap_ld_nxt = '0;
          w_gap_nxt    = '0;
          w_load       = 1'b1;
          w_load_val   = '0;
        end else if (r_state == SHIFT) begin
          w_shift = 1'b1;
          if (r_bit_cnt == '0) begin
            w_rep_nxt = r_rep_cnt - 1'b1;
            if (r_rep_cnt == REPS_W'(1)) begin
              w_state_nxt = DONE;
            end else if (r_gap_ld == '0) begin
              // Back-to-back repetition: reload overrides the shift.
              w_load    = 1'b1;
              w_bit_nxt = BIT_LAST;
            end else begin
              w_gap_nxt   = r_gap_ld;
              w_state_nxt = GAP;
            end
          end else begin
            w_bit_nxt = r_bit_cnt - 1'b1;
          end
        end else begin
          // GAP: leaves on the cycle where the count reaches 1, so the
          // line stays idle for exactly gap_ld cycles.
          if (r_gap_cnt == GAP_W'(1)) begin
            w_gap_nxt   = '0;
            w_load      = 1'b1;
            w_bit_nxt   = BIT_LAST;
            w_state_nxt = SHIFT;
          end else begin
            w_gap_nxt = r_gap_cnt - 1'b1;
          end
        end
      end

      DONE: begin
        w_state_nxt = IDLE;
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign bus.valid     = (r_state == SHIFT);
  assign bus.x_out     = (r_state == SHIFT) & w_msb;
  assign bus.busy      = (r_state == SHIFT) || (r_state == GAP);
  assign bus.done      = (r_state == DONE);
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_seq_gen.sv
// tb_seq_gen: directed bench for seq_gen (PAT_W = 4, default pattern 1010).
module tb_seq_gen;
  import seq_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seq_gen_if #(.PAT_W(4)) bus();

  seq_gen #(.PAT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- scoreboard state ----------------
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [1:0] exp_q[$];   // {valid, x_out} expected per cycle

  // Reference 1010 detector fed from the serial line (overlapping matches).
  logic [3:0] hist    = 4'b0;
  int         det_cnt = 0;
  always @(posedge clk) begin
    if (bus.valid) begin
      if ({hist[2:0], bus.x_out} == 4'b1010) det_cnt <= det_cnt + 1;
      hist <= {hist[2:0], bus.x_out};
    end else begin
      hist <= 4'b0;
    end
  end

  // ---------------- checkers ----------------
  task automatic check1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic checkn(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_burst(input logic ud, input logic [3:0] pat,
                             input logic [7:0] r, input logic [3:0] g);
    @(negedge clk);
    bus.use_def = ud;
    bus.pattern = pat;
    bus.reps    = r;
    bus.gap     = g;
    bus.start   = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic push_bits(input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({1'b1, bits[n-1-i]});
  endtask

  task automatic push_gap(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(2'b00);
  endtask

  // Called at the cycle-1 observation point; returns at the cycle after
  // the last expected entry.
  task automatic drain_stream(input string tag);
    logic [1:0] e;
    int         k;
    k = 1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check1($sformatf("%s c%0d valid", tag, k), bus.valid, e[1]);
      check1($sformatf("%s c%0d x_out", tag, k), bus.x_out, e[0]);
      check1($sformatf("%s c%0d busy",  tag, k), bus.busy, 1'b1);
      check1($sformatf("%s c%0d done",  tag, k), bus.done, 1'b0);
      tick();
      k++;
    end
  endtask

  task automatic check_end(input string tag);
    check1({tag, " done pulse"}, bus.done, 1'b1);
    check1({tag, " done busy"},  bus.busy, 1'b0);
    check1({tag, " done valid"}, bus.valid, 1'b0);
    tick();
    check1({tag, " post done"}, bus.done, 1'b0);
    checkn({tag, " post state"}, int'(bus.dbg_state), int'(IDLE));
  endtask

  // ---------------- directed sequence ----------------
  logic [5:0] abort_bits;
  int         det_base;

  initial begin
    reset       = 1'b0;
    bus.start   = 1'b0;
    bus.use_def = 1'b0;
    bus.pattern = 4'b0000;
    bus.reps    = 8'd0;
    bus.gap     = 4'd0;
    bus.abort   = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check1("rst x_out", bus.x_out, 1'b0);
    check1("rst valid", bus.valid, 1'b0);
    check1("rst busy",  bus.busy, 1'b0);
    check1("rst done",  bus.done, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    checkn("rst idle state", int'(bus.dbg_state), int'(IDLE));
    check1("rst idle valid", bus.valid, 1'b0);

    // Default pattern, single repetition
    start_burst(1'b1, 4'b0000, 8'd1, 4'd0);
    push_bits(16'b1010, 4);
    drain_stream("def");
    check_end("def");

    // Pattern 1100, three repetitions, gap of two
    start_burst(1'b0, 4'b1100, 8'd3, 4'd2);
    push_bits(16'b1100, 4); push_gap(2);
    push_bits(16'b1100, 4); push_gap(2);
    push_bits(16'b1100, 4);
    drain_stream("gap");
    check_end("gap");

    // Back-to-back repetitions, no bubble
    start_burst(1'b1, 4'b0000, 8'd2, 4'd0);
    push_bits(16'b10101010, 8);
    drain_stream("b2b");
    check_end("b2b");

    // Zero repetitions: immediate done, no bits
    start_burst(1'b1, 4'b0000, 8'd0, 4'd3);
    check1("rep0 done",  bus.done, 1'b1);
    check1("rep0 valid", bus.valid, 1'b0);
    check1("rep0 busy",  bus.busy, 1'b0);
    tick();
    check1("rep0 post done",  bus.done, 1'b0);
    check1("rep0 post valid", bus.valid, 1'b0);
    checkn("rep0 post state", int'(bus.dbg_state), int'(IDLE));

    // Abort in 6th bit; start/pattern changes mid-burst are ignored
    start_burst(1'b0, 4'b1100, 8'd4, 4'd0);
    abort_bits = 6'b110011;
    for (int k = 0; k < 6; k++) begin
      check1($sformatf("abt c%0d valid", k + 1), bus.valid, 1'b1);
      check1($sformatf("abt c%0d x_out", k + 1), bus.x_out, abort_bits[5-k]);
      if (k == 1) begin
        bus.start   = 1'b1;
        bus.pattern = 4'b0011;
        bus.use_def = 1'b1;
      end
      if (k == 3) bus.start = 1'b0;
      if (k == 5) bus.abort = 1'b1;
      tick();
    end
    bus.abort = 1'b0;
    checkn("abt state", int'(bus.dbg_state), int'(IDLE));
    check1("abt busy",  bus.busy, 1'b0);
    check1("abt valid", bus.valid, 1'b0);
    check1("abt done",  bus.done, 1'b0);
    tick();
    check1("abt done later", bus.done, 1'b0);
    check1("abt valid later", bus.valid, 1'b0);

    // Asynchronous reset during the 2nd bit
    start_burst(1'b1, 4'b0000, 8'd1, 4'd0);
    check1("mrst c1 x_out", bus.x_out, 1'b1);
    tick();
    check1("mrst c2 valid", bus.valid, 1'b1);
    check1("mrst c2 busy",  bus.busy, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check1("mrst x_out", bus.x_out, 1'b0);
    check1("mrst valid", bus.valid, 1'b0);
    check1("mrst busy",  bus.busy, 1'b0);
    check1("mrst done",  bus.done, 1'b0);
    checkn("mrst state", int'(bus.dbg_state), int'(IDLE));
    @(negedge clk);
    reset = 1'b1;
    tick();
    checkn("mrst idle state", int'(bus.dbg_state), int'(IDLE));
    check1("mrst idle valid", bus.valid, 1'b0);
    tick();
    check1("mrst idle done", bus.done, 1'b0);

    // Loopback into the 1010 detector: 101010101010 holds matches
    // starting at bit offsets 0, 2, 4, 6 and 8.
    det_base = det_cnt;
    start_burst(1'b1, 4'b0000, 8'd3, 4'd0);
    push_bits(16'b101010101010, 12);
    drain_stream("loop");
    check_end("loop");
    checkn("loop det matches", det_cnt - det_base, 5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
